// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int unsigned DEF_MAX_D_STREAK = 32'd4;
    localparam int unsigned DEF_TIMEOUT      = 32'd255;
    localparam logic [31:0] DEF_ERR_DATA     = 32'h0000_0000;

    // Width of the consecutive-data-grant counter; MAX_D_STREAK must fit in it.
    localparam int unsigned STREAK_W = 32'd8;

    // Watchdog counter width: wide enough for TIMEOUT, never narrower than 8 bits.
    function automatic int unsigned wd_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 32'd1);
        return (w < 32'd8) ? 32'd8 : w;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle watchdog: counts access cycles without an acknowledge and flags
// the cycle on which the TIMEOUT-th such cycle is being spent.
module mem_watchdog
    import arm_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = wd_width(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Count value reached during the last permitted cycle without an ack.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on a new access, step while waiting, hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and
// the data stage (D). Data wins contention until it has taken MAX_D_STREAK
// grants in a row while fetch waited; a watchdog aborts hung accesses.
module mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA     = DEF_ERR_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_f,
    output logic        stall_m,
    output logic        bus_err
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic [STREAK_W-1:0] d_streak_q,  d_streak_d;
    logic [31:0]         i_rdata_q,   i_rdata_d;
    logic [31:0]         d_rdata_q,   d_rdata_d;
    logic                i_ready_q,   i_ready_d;
    logic                d_ready_q,   d_ready_d;
    logic                bus_err_q,   bus_err_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [31:0]         mem_addr_q,  mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic grant_d_s;
    logic wd_clr_s;
    logic wd_en_s;
    logic wd_expired_s;

    // Any pending request in IDLE produces a grant, so that is when the
    // watchdog restarts; it then counts every BUSY cycle that has no ack.
    assign wd_clr_s = (state_q == IDLE) && (i_req || d_req);
    assign wd_en_s  = (state_q == BUSY) && !mem_ack;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    // Arbitration, access FSM and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        d_streak_d  = d_streak_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d_s   = 1'b0;

        case (state_q)
            IDLE: begin
                // Data goes first unless fetch is waiting and data has used up its streak.
                grant_d_s = d_req && (!i_req || (d_streak_q != STREAK_MAX));
                if (grant_d_s) begin
                    state_d     = BUSY;
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (!i_req) begin
                        d_streak_d = {STREAK_W{1'b0}};
                    end else if (d_streak_q != STREAK_MAX) begin
                        d_streak_d = d_streak_q + STREAK_W'(1);
                    end else begin
                        d_streak_d = d_streak_q;
                    end
                end else if (i_req) begin
                    state_d     = BUSY;
                    owner_d     = OWN_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = 32'h0000_0000;
                    d_streak_d  = {STREAK_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end

            BUSY: begin
                // An ack on the expiry cycle is still a normal completion.
                if (mem_ack || wd_expired_s) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0000_0000;
                    mem_wdata_d = 32'h0000_0000;
                    i_ready_d   = (owner_q == OWN_I);
                    d_ready_d   = (owner_q == OWN_D);
                    bus_err_d   = !mem_ack;
                    if (!mem_ack) begin
                        if (owner_q == OWN_I) begin
                            i_rdata_d = ERR_DATA;
                        end else begin
                            d_rdata_d = ERR_DATA;
                        end
                    end else if (!mem_we_q) begin
                        if (owner_q == OWN_I) begin
                            i_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        // Stores complete without touching the read-data register.
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    state_d = BUSY;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = 32'h0000_0000;
                mem_wdata_d = 32'h0000_0000;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            d_streak_q  <= {STREAK_W{1'b0}};
            i_rdata_q   <= 32'h0000_0000;
            d_rdata_q   <= 32'h0000_0000;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            d_streak_q  <= d_streak_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            bus_err_q   <= bus_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Hazard-unit stalls: a requester is held until its completion pulse.
    assign stall_f = i_req & ~i_ready_q;
    assign stall_m = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: two requesters, a
// variable-latency memory and a reference model of the arbitration rules.
module tb_mem_arbiter;
    import arm_mem_pkg::*;

    localparam int unsigned MAXS = 4;
    localparam int unsigned TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam int          NREQ = 40;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ready, d_ready, mem_req, mem_we, stall_f, stall_m, bus_err;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t sbq[$];
    bit   resp_en     = 1'b0;
    bit   resp_active = 1'b0;
    bit   dir_ack     = 1'b0;
    int   gap_max     = 3;
    bit   done        = 1'b0;

    logic        snap_i_req, snap_d_req, snap_d_we;
    logic [31:0] snap_i_addr, snap_d_addr, snap_d_wdata;

    mem_arbiter #(
        .MAX_D_STREAK (MAXS),
        .TIMEOUT      (TO),
        .ERR_DATA     (ERRD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_f   (stall_f),
        .stall_m   (stall_m),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Cycle counter and snapshot of requester inputs at each arbitration edge.
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        snap_i_req   <= i_req;
        snap_d_req   <= d_req;
        snap_d_we    <= d_we;
        snap_i_addr  <= i_addr;
        snap_d_addr  <= d_addr;
        snap_d_wdata <= d_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp_v);
        check(name, {31'd0, act}, {31'd0, exp_v});
    endtask

    // One requester: random gaps, holds its request until the ready pulse.
    task automatic requester(input bit is_d);
        int gap;
        int w;
        @(posedge clk); #1;
        for (int n = 0; n < NREQ; n++) begin
            gap = $urandom_range(gap_max, 0);
            if (is_d) d_req = 1'b0; else i_req = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            if (is_d) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(1, 0));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else begin
                i_req  = 1'b1;
                i_addr = $urandom;
            end
            w = 0;
            while (!(is_d ? d_ready : i_ready) && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            check1(is_d ? "d_ready_in_bound" : "i_ready_in_bound", is_d ? d_ready : i_ready, 1'b1);
            @(posedge clk); #1;
        end
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
    endtask

    // Memory model plus reference arbiter: predicts the owner of every access,
    // checks the memory bus, plans the ack and queues the expected completion.
    initial begin : responder
        int          c0, due, ackc, streak, r;
        bit          tmo;
        logic        is_d, x_we;
        logic [31:0] x_addr, x_wdata, plan, exp_i_rd, exp_d_rd;
        exp_t        e;
        c0 = 0; due = 0; ackc = -1; streak = 0; r = 0; tmo = 1'b0;
        is_d = 1'b0; x_we = 1'b0; x_addr = 32'd0; x_wdata = 32'd0; plan = 32'd0;
        exp_i_rd = 32'd0; exp_d_rd = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_ack   = resp_en ? 1'b0 : dir_ack;
            mem_rdata = $urandom;
            if (resp_en) begin
                if (!resp_active && mem_req) begin
                    c0 = cyc;
                    check1("req_pending_at_grant", snap_i_req | snap_d_req, 1'b1);
                    is_d = snap_d_req && (!snap_i_req || streak < MAXS);
                    if (is_d) streak = snap_i_req ? ((streak < MAXS) ? streak + 1 : streak) : 0;
                    else      streak = 0;
                    x_addr  = is_d ? snap_d_addr : snap_i_addr;
                    x_we    = is_d ? snap_d_we : 1'b0;
                    x_wdata = is_d ? snap_d_wdata : 32'd0;
                    check("grant_addr", mem_addr, x_addr);
                    check1("grant_we", mem_we, x_we);
                    r   = $urandom_range(9, 0);
                    tmo = (r == 7);
                    if (r <= 5)      ackc = c0 + r % 4;
                    else if (r == 6) ackc = c0 + TO - 1;
                    else if (r == 7) ackc = -1;
                    else             ackc = c0 + $urandom_range(TO - 2, 0);
                    due  = tmo ? c0 + TO : ackc + 1;
                    plan = $urandom;
                    if (tmo)       e.rdata = ERRD;
                    else if (x_we) e.rdata = exp_d_rd;
                    else           e.rdata = plan;
                    if (is_d) exp_d_rd = e.rdata; else exp_i_rd = e.rdata;
                    e.is_d = is_d;
                    e.err  = tmo;
                    e.due  = due;
                    sbq.push_back(e);
                    resp_active = 1'b1;
                end
                if (resp_active) begin
                    if (cyc < due) begin
                        check1("busy_mem_req", mem_req, 1'b1);
                        check("busy_mem_addr", mem_addr, x_addr);
                        check1("busy_mem_we", mem_we, x_we);
                        if (is_d) check("busy_mem_wdata", mem_wdata, x_wdata);
                        if (cyc == ackc) begin
                            mem_ack   = 1'b1;
                            mem_rdata = plan;
                        end
                    end else begin
                        check1("resp_mem_req_low", mem_req, 1'b0);
                        resp_active = 1'b0;
                    end
                end else begin
                    check("idle_mem_bus_zero", {31'd0, mem_we} | mem_addr | mem_wdata, 32'd0);
                end
            end
        end
    end

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        check1("stall_f", stall_f, i_req & ~i_ready);
        check1("stall_m", stall_m, d_req & ~d_ready);
        if (i_ready || d_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", {30'd0, i_ready, d_ready}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("ready_port", {30'd0, i_ready, d_ready}, e.is_d ? 32'd1 : 32'd2);
                check("ready_cycle", cyc, e.due);
                check("ready_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                check1("ready_bus_err", bus_err, e.err);
            end
        end else begin
            check1("bus_err_without_ready", bus_err, 1'b0);
            if (sbq.size() != 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                check("missing_ready", cyc, e.due);
            end
        end
    end

    // Stimulus sequencer: reset, two randomized phases, reset during an access.
    initial begin : main
        int w;
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_i_ready", i_ready, 1'b0);
        check1("rst_d_ready", d_ready, 1'b0);
        check1("rst_bus_err", bus_err, 1'b0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check1("rst_stall_f", stall_f, 1'b1);
        check1("rst_stall_m", stall_m, 1'b1);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0; reset = 1'b0;
        resp_en = 1'b1;

        gap_max = 3;
        fork
            requester(1'b0);
            requester(1'b1);
        join
        gap_max = 0;
        fork
            requester(1'b0);
            requester(1'b1);
        join
        repeat (4) @(posedge clk);
        check("queue_drained", sbq.size(), 32'd0);

        // Reset while an access is outstanding, then a stray ack.
        resp_en = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        w = 0;
        while (!mem_req && w < 10) begin @(posedge clk); #1; w++; end
        check1("dir_busy_seen", mem_req, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check1("dir_rst_mem_req", mem_req, 1'b0);
        check1("dir_rst_d_ready", d_ready, 1'b0);
        reset = 1'b0; d_req = 1'b0;
        dir_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check1("late_ack_mem_req", mem_req, 1'b0);
            check1("late_ack_d_ready", d_ready, 1'b0);
            check1("late_ack_i_ready", i_ready, 1'b0);
            check("late_ack_d_rdata", d_rdata, 32'd0);
        end
        dir_ack = 1'b0;
        @(negedge clk);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin : guard
        #400000;
        if (!done) begin
            miscompares++;
            $display("FAIL global_timeout: actual cycle %0d required completion", cyc);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

endmodule
